// File: rtl/clock_set_controller.sv
// Mode/time-setting controller for the 74LSXX digital clock: 1 Hz prescaler,
// debounced keys, registered count enables, sec_clr and display blink.
module clock_set_controller #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    ILLEGAL  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic          en_sec_q, en_sec_d;
  logic          en_min_q, en_min_d;
  logic          en_hour_q, en_hour_d;
  logic          sec_clr_q, sec_clr_d;
  logic          blink_q, blink_d;

  // Key index 0 = mode, 1 = inc.
  logic [1:0]    keys_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    lvl_q, lvl_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];

  logic tick;
  logic mode_press;
  logic inc_press;

  assign keys_raw = {key_inc, key_mode};

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      dcnt_d[i]  = '0;
      lvl_d[i]   = lvl_q[i];
      press_d[i] = 1'b0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (dcnt_q[i] == DMAX) begin
          lvl_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign tick       = (presc_q == TMAX);
  assign mode_press = press_q[0];
  // A mode press in the same cycle swallows the inc press.
  assign inc_press  = press_q[1] & ~press_q[0];

  always_comb begin
    state_d   = state_q;
    en_sec_d  = 1'b0;
    en_min_d  = 1'b0;
    en_hour_d = 1'b0;
    sec_clr_d = 1'b0;
    unique case (state_q)
      RUN: begin
        en_sec_d  = tick;
        en_min_d  = tick & sec_carry;
        en_hour_d = tick & sec_carry & min_carry;
        if (mode_press) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        en_hour_d = inc_press;
        if (mode_press) state_d = SET_MIN;
      end
      SET_MIN: begin
        en_min_d = inc_press;
        if (mode_press) begin
          state_d   = RUN;
          sec_clr_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    presc_d = (sec_clr_d || tick) ? '0 : presc_q + CW'(1);

    if (state_d == RUN || state_d != state_q) begin
      blink_d = 1'b1;
    end else if (tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      presc_q   <= '0;
      en_sec_q  <= 1'b0;
      en_min_q  <= 1'b0;
      en_hour_q <= 1'b0;
      sec_clr_q <= 1'b0;
      blink_q   <= 1'b1;
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      press_q   <= '0;
      for (int unsigned i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      en_sec_q  <= en_sec_d;
      en_min_q  <= en_min_d;
      en_hour_q <= en_hour_d;
      sec_clr_q <= sec_clr_d;
      blink_q   <= blink_d;
      sync1_q   <= keys_raw;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      for (int unsigned i = 0; i < 2; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign en_sec  = en_sec_q;
  assign en_min  = en_min_q;
  assign en_hour = en_hour_q;
  assign sec_clr = sec_clr_q;
  assign mode    = state_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: edge-indexed behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_clock_set_controller;

  localparam int TD = 10;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       sec_carry = 1'b0;
  logic       min_carry = 1'b0;
  logic       en_sec, en_min, en_hour, sec_clr, blink;
  logic [1:0] mode;

  clock_set_controller #(.TICK_DIV(TD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .sec_carry(sec_carry), .min_carry(min_carry),
    .en_sec(en_sec), .en_min(en_min), .en_hour(en_hour),
    .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edges are numbered from 1 after reset release; raw key samples are
  // recorded per edge and the debounce rule is evaluated over that history.
  int  e;
  int  r;
  bit  hist [2][0:4095];
  bit  m_lvl [2];
  int  m_last [2];
  bit  m_pend [2];
  bit  x_es, x_em, x_eh, x_sc, x_blink;
  int  x_mode;

  always @(posedge clk or posedge rst) begin : model
    int  ne, nm, idx, raw_i;
    bit  tk, mp, ip, flip, seenv, es, em, eh;
    if (rst) begin
      e <= 0; r <= 0;
      x_es <= 0; x_em <= 0; x_eh <= 0; x_sc <= 0; x_blink <= 1; x_mode <= 0;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] <= 0; m_last[k] <= -100; m_pend[k] <= 0;
      end
    end else begin
      ne = e + 1;
      tk = (((ne - 1 - r) % TD) == TD - 1);
      mp = m_pend[0];
      ip = m_pend[1] && !mp;
      es = 0; em = 0; eh = 0;
      if (x_mode == 0) begin
        es = tk; em = tk && sec_carry; eh = tk && sec_carry && min_carry;
      end else if (x_mode == 1) begin
        eh = ip;
      end else if (x_mode == 2) begin
        em = ip;
      end
      nm = mp ? (x_mode + 1) % 3 : x_mode;
      x_es <= es; x_em <= em; x_eh <= eh;
      x_sc <= (x_mode == 2) && mp;
      if ((x_mode == 2) && mp) r <= ne;
      x_mode <= nm;
      if (nm == 0 || nm != x_mode) x_blink <= 1;
      else if (tk) x_blink <= !x_blink;
      hist[0][ne % 4096] <= key_mode;
      hist[1][ne % 4096] <= key_inc;
      for (int k = 0; k < 2; k++) begin
        flip = 1;
        for (int j = 0; j < DB; j++) begin
          idx   = ne - j;
          raw_i = idx - 2;
          seenv = (raw_i >= 1) ? hist[k][raw_i % 4096] : 1'b0;
          if (seenv == m_lvl[k] || idx <= m_last[k]) flip = 0;
        end
        if (flip) begin
          m_lvl[k]  <= !m_lvl[k];
          m_last[k] <= ne;
          m_pend[k] <= !m_lvl[k];
        end else begin
          m_pend[k] <= 0;
        end
      end
      e <= ne;
    end
  end

  int n_sec = 0, n_min = 0, n_hour = 0;

  always begin : compare
    @(posedge clk);
    #1;
    if (!rst) begin
      check("en_sec",  en_sec,  x_es);
      check("en_min",  en_min,  x_em);
      check("en_hour", en_hour, x_eh);
      check("sec_clr", sec_clr, x_sc);
      check("mode",    mode,    x_mode);
      check("blink",   blink,   x_blink);
      if (en_sec)  n_sec++;
      if (en_min)  n_min++;
      if (en_hour) n_hour++;
    end
  end

  task automatic to_edge(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit pm, input bit pi);
    @(negedge clk);
    key_mode = pm; key_inc = pi;
    repeat (8) @(negedge clk);
    key_mode = 0; key_inc = 0;
    wait_edges(12);
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int k, b, es_edge, h0, s0, m0;
    logic v1;
    bit found;

    repeat (3) @(negedge clk);
    #1;
    check("rst_mode", mode, 0);
    check("rst_blink", blink, 1);
    check("rst_en_sec", en_sec, 0);
    check("rst_sec_clr", sec_clr, 0);
    @(negedge clk);
    rst = 0;

    to_edge(10); check("first_tick", en_sec, 1);
    to_edge(11); check("tick_one_cycle", en_sec, 0);
    to_edge(20); check("second_tick", en_sec, 1);
    check("no_min_run", en_min, 0);

    @(negedge clk); sec_carry = 1; min_carry = 0;
    to_edge(30);
    check("carry_sec", en_sec, 1);
    check("carry_min", en_min, 1);
    check("carry_nohour", en_hour, 0);
    @(negedge clk); min_carry = 1;
    to_edge(40);
    check("chain_sec", en_sec, 1);
    check("chain_min", en_min, 1);
    check("chain_hour", en_hour, 1);
    @(negedge clk); sec_carry = 0; min_carry = 0;

    // Long hold: one mode step at edge 6 counted from the first high sample.
    @(negedge clk);
    k = e; key_mode = 1;
    to_edge(k + 6); check("mode_before_edge6", mode, 0);
    to_edge(k + 7); check("mode_at_edge6", mode, 1);
    check("blink_on_entry", blink, 1);
    repeat (93) @(negedge clk);
    key_mode = 0;
    wait_edges(12);
    check("mode_once", mode, 1);

    h0 = n_hour;
    @(negedge clk); key_inc = 1;
    repeat (3) @(negedge clk);
    key_inc = 0;
    wait_edges(20);
    check("glitch_no_hour", n_hour - h0, 0);

    h0 = n_hour; s0 = n_sec;
    press(0, 1);
    press(0, 1);
    check("two_hour_pulses", n_hour - h0, 2);
    check("no_sec_in_set", n_sec - s0, 0);

    b = e + 1;
    while ((b % TD) != 5) b++;
    to_edge(b); v1 = blink;
    to_edge(b + TD); check("blink_toggle", blink, {31'b0, ~v1});
    to_edge(b + 2 * TD); check("blink_toggle2", blink, {31'b0, v1});

    press(1, 0);
    check("mode_set_min", mode, 2);
    m0 = n_min;
    press(0, 1);
    check("one_min_pulse", n_min - m0, 1);

    @(negedge clk); key_mode = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (sec_clr) found = 1;
    end
    check("sec_clr_seen", found, 1);
    es_edge = e;
    check("mode_back_run", mode, 0);
    check("blink_run", blink, 1);
    wait_edges(1);
    check("sec_clr_one_cycle", sec_clr, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (en_sec) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("en_sec_after_clr", found, 1);
    check("en_sec_spacing", e - es_edge, TD);
    @(negedge clk); key_mode = 0;
    wait_edges(10);

    press(1, 0);
    check("mode_set_hour_again", mode, 1);
    h0 = n_hour;
    press(1, 1);
    check("simul_mode_wins", mode, 2);
    check("simul_no_hour", n_hour - h0, 0);

    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("async_mode", mode, 0);
    check("async_blink", blink, 1);
    check("async_en", {en_sec, en_min, en_hour, sec_clr}, 0);
    @(negedge clk);
    rst = 0;
    to_edge(9);  check("resume_pre", en_sec, 0);
    to_edge(10); check("resume_tick", en_sec, 1);
    check("resume_mode", mode, 0);

    wait_edges(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
